// File: rtl/cart_loader.sv
// Packs the ROM download byte stream into SDRAM words and writes them over a toggle req/ack channel.
// Latency: a word issues the cycle after its push when the channel is idle; the mask search adds at most ADDR_W cycles.
// Backpressure: none upstream. A word that meets a full buffer is dropped and overflow is set; the core stays in reset until every write retires.
module cart_loader #(
  parameter int ADDR_W        = 22,
  parameter int WORD_BYTES    = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int MIN_MASK_BITS = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rom_loading,
  input  logic [7:0]              rom_do,
  input  logic                    rom_do_valid,
  output logic                    mem_req,
  input  logic                    mem_ack,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_din,
  output logic [WORD_BYTES-1:0]   mem_be,
  output logic                    sys_reset,
  output logic [ADDR_W:0]         cart_size,
  output logic                    cart_hdr,
  output logic [ADDR_W-1:0]       cart_mask,
  output logic                    busy,
  output logic                    overflow
);

  localparam int DW     = 8 * WORD_BYTES;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int KW     = $clog2(ADDR_W + 1);
  localparam int K0     = (MIN_MASK_BITS > ADDR_W) ? ADDR_W : MIN_MASK_BITS;

  localparam logic [ADDR_W-1:0] ALIGN     = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   HDR_BYTES = (ADDR_W+1)'(512);
  localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]    PTR_FULL  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, MASK, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [DW-1:0]         dat;
    logic [WORD_BYTES-1:0] be;
  } word_t;

  state_t                state_q, state_d;
  logic                  rom_loading_q, rom_loading_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [DW-1:0]         pack_q, pack_d;
  logic [WORD_BYTES-1:0] fill_q, fill_d;
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]         mem_din_q, mem_din_d;
  logic [WORD_BYTES-1:0] mem_be_q, mem_be_d;
  logic                  sys_reset_q, sys_reset_d;
  logic [ADDR_W:0]       cart_size_q, cart_size_d;
  logic                  cart_hdr_q, cart_hdr_d;
  logic [ADDR_W-1:0]     cart_mask_q, cart_mask_d;
  logic                  overflow_q, overflow_d;
  logic [KW-1:0]         k_q, k_d;

  word_t                 fifo_mem_q [FIFO_DEPTH];
  word_t                 head;
  word_t                 push_word;
  logic                  push;
  logic                  pop;
  logic                  rise;
  logic                  fall;
  logic                  req_idle;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  can_push;
  logic [PTR_W:0]        fifo_cnt;
  logic [ADDR_W:0]       pow;
  logic [ADDR_W:0]       eff;
  int                    lane;

  assign head       = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (fifo_cnt == PTR_FULL);
  assign req_idle   = (mem_ack == mem_req_q);
  assign rise       = rom_loading && !rom_loading_q;
  assign fall       = !rom_loading && rom_loading_q;

  // Next-state, byte packing, buffer push/pop and request issue.
  always_comb begin
    state_d       = state_q;
    rom_loading_d = rom_loading;
    count_d       = count_q;
    pack_d        = pack_q;
    fill_d        = fill_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    mem_be_d      = mem_be_q;
    sys_reset_d   = sys_reset_q;
    cart_size_d   = cart_size_q;
    cart_hdr_d    = cart_hdr_q;
    cart_mask_d   = cart_mask_q;
    overflow_d    = overflow_q;
    k_d           = k_q;
    push          = 1'b0;
    push_word     = '0;
    pop           = 1'b0;
    lane          = 0;
    pow           = CNT_ONE << k_q;
    eff           = cart_size_q - (cart_hdr_q ? HDR_BYTES : '0);

    // A new download discards buffered words, so nothing pops on that cycle.
    if (!fifo_empty && req_idle && !rise) begin
      pop        = 1'b1;
      mem_req_d  = ~mem_req_q;
      mem_addr_d = head.addr;
      mem_din_d  = head.dat;
      mem_be_d   = head.be;
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
    end
    // Popping frees a slot for a push in the same cycle.
    can_push = !fifo_full || pop;

    if (rise) begin
      state_d     = LOAD;
      count_d     = '0;
      pack_d      = '0;
      fill_d      = '0;
      overflow_d  = 1'b0;
      wr_ptr_d    = rd_ptr_q;
      sys_reset_d = 1'b1;
      cart_size_d = '0;
      cart_hdr_d  = 1'b0;
      cart_mask_d = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (fall) begin
            state_d = FLUSH;
          end else if (rom_do_valid) begin
            if (count_q[ADDR_W]) begin
              overflow_d = 1'b1;
            end else begin
              lane = (WORD_BYTES == 1) ? 0 : int'(count_q[LANE_W-1:0]);
              pack_d[8*lane +: 8] = rom_do;
              fill_d[lane]        = 1'b1;
              count_d             = count_q + CNT_ONE;
              if (lane == WORD_BYTES - 1) begin
                push_word.addr = count_q[ADDR_W-1:0] & ALIGN;
                push_word.dat  = pack_d;
                push_word.be   = '1;
                pack_d         = '0;
                fill_d         = '0;
                if (can_push) push = 1'b1;
                else          overflow_d = 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          if (fill_q == '0) begin
            state_d = DRAIN;
          end else if (can_push) begin
            push           = 1'b1;
            push_word.addr = count_q[ADDR_W-1:0] & ALIGN;
            push_word.dat  = pack_q;
            push_word.be   = fill_q;
            pack_d         = '0;
            fill_d         = '0;
            state_d        = DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && req_idle) begin
            cart_size_d = count_q;
            cart_hdr_d  = (count_q[9:0] == 10'd512);
            k_d         = KW'(K0);
            state_d     = MASK;
          end
        end
        MASK: begin
          if ((k_q >= KW'(ADDR_W)) || (pow >= eff)) begin
            cart_mask_d = ADDR_W'(pow - CNT_ONE);
            state_d     = DONE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        DONE: begin
          sys_reset_d = 1'b0;
        end
        default: begin
        end
      endcase
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rom_loading_q <= 1'b0;
      count_q       <= '0;
      pack_q        <= '0;
      fill_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_be_q      <= '0;
      sys_reset_q   <= 1'b1;
      cart_size_q   <= '0;
      cart_hdr_q    <= 1'b0;
      cart_mask_q   <= '0;
      overflow_q    <= 1'b0;
      k_q           <= '0;
    end else begin
      state_q       <= state_d;
      rom_loading_q <= rom_loading_d;
      count_q       <= count_d;
      pack_q        <= pack_d;
      fill_q        <= fill_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      mem_be_q      <= mem_be_d;
      sys_reset_q   <= sys_reset_d;
      cart_size_q   <= cart_size_d;
      cart_hdr_q    <= cart_hdr_d;
      cart_mask_q   <= cart_mask_d;
      overflow_q    <= overflow_d;
      k_q           <= k_d;
    end
  end

  // Buffer storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= push_word;
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_be    = mem_be_q;
  assign sys_reset = sys_reset_q;
  assign cart_size = cart_size_q;
  assign cart_hdr  = cart_hdr_q;
  assign cart_mask = cart_mask_q;
  assign overflow  = overflow_q;
  assign busy      = !((state_q == IDLE) || (state_q == DONE));

endmodule

// File: tb/tb_cart_loader.sv
// Bench for cart_loader: table of downloads plus hand sequences for restart-in-drain and mid-load reset.
// A toggle-ack memory model with programmable delay checks every write as it issues.
// Parameters are shrunk (12-bit region, 256-byte mask floor) so saturation and clamping are reachable.
module tb_cart_loader;
  localparam int AW  = 12;
  localparam int WB  = 2;
  localparam int FD  = 4;
  localparam int MMB = 8;
  localparam int CAP = 1 << AW;

  logic            clk = 1'b0;
  logic            reset;
  logic            rom_loading;
  logic [7:0]      rom_do;
  logic            rom_do_valid;
  logic            mem_req;
  logic            mem_ack = 1'b0;
  logic [AW-1:0]   mem_addr;
  logic [8*WB-1:0] mem_din;
  logic [WB-1:0]   mem_be;
  logic            sys_reset;
  logic [AW:0]     cart_size;
  logic            cart_hdr;
  logic [AW-1:0]   cart_mask;
  logic            busy;
  logic            overflow;

  cart_loader #(.ADDR_W(AW), .WORD_BYTES(WB), .FIFO_DEPTH(FD), .MIN_MASK_BITS(MMB)) dut (
    .clk(clk), .reset(reset), .rom_loading(rom_loading), .rom_do(rom_do),
    .rom_do_valid(rom_do_valid), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be), .sys_reset(sys_reset),
    .cart_size(cart_size), .cart_hdr(cart_hdr), .cart_mask(cart_mask),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // memory model state
  bit   ack_hold = 1'b0;
  int   ack_dly = 3;
  logic last_req = 1'b0;
  int   cd = 0;
  int   wr_cnt = 0;
  int   exp_next = 0;
  int   cur_total = 0;
  bit   contig = 1'b1;

  typedef struct {
    int n; int gap; int dly;
    int size; int hdr; int mask; int writes; int ovf; int contig;
  } vec_t;
  vec_t vecs[13];

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 13 + 5) & 255);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_write();
    bit ok;
    int a;
    logic [1:0] be_e;
    ok = 1'b1;
    a  = int'(mem_addr);
    if (contig || wr_cnt < FD + 1) ok = ok && (a == exp_next);
    else                           ok = ok && (a >= exp_next) && (a % 2 == 0);
    be_e = (a + 1 < cur_total) ? 2'b11 : 2'b01;
    ok = ok && (mem_be == be_e) && (mem_din[7:0] == pat(a));
    if (be_e[1]) ok = ok && (mem_din[15:8] == pat(a + 1));
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL write#%0d: got addr=0x%0h din=0x%0h be=%b expected addr=0x%0h be=%b din_lo=0x%0h",
               wr_cnt, mem_addr, mem_din, mem_be, exp_next, be_e, pat(a));
    end
    exp_next = a + 2;
    wr_cnt++;
  endtask

  // Toggle-ack memory: record each new request, acknowledge after ack_dly cycles unless held.
  always @(negedge clk) begin
    if (reset) begin
      mem_ack  = 1'b0;
      last_req = 1'b0;
      cd       = 0;
    end else begin
      if (mem_req !== last_req) begin
        last_req = mem_req;
        cd       = ack_dly;
        check_write();
      end
      if (mem_ack !== last_req && !ack_hold) begin
        if (cd <= 0) mem_ack = last_req;
        else         cd--;
      end
    end
  end

  task automatic mon_start(input int total, input bit c);
    wr_cnt    = 0;
    exp_next  = 0;
    cur_total = total;
    contig    = c;
  endtask

  task automatic feed(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rom_do       = pat(i);
      rom_do_valid = 1'b1;
      for (int g = 1; g < gap; g++) begin
        @(negedge clk);
        rom_do_valid = 1'b0;
      end
    end
    @(negedge clk);
    rom_do_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sys_reset !== 1'b0 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_in_time"}, 32'(n < 30000), 32'd1);
    chk({name, "_req_retired"}, 32'(mem_req === mem_ack), 32'd1);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_mem_req"},   32'(mem_req),   32'd0);
    chk({name, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({name, "_mem_din"},   32'(mem_din),   32'd0);
    chk({name, "_mem_be"},    32'(mem_be),    32'd0);
    chk({name, "_sys_reset"}, 32'(sys_reset), 32'd1);
    chk({name, "_cart_size"}, 32'(cart_size), 32'd0);
    chk({name, "_cart_hdr"},  32'(cart_hdr),  32'd0);
    chk({name, "_cart_mask"}, 32'(cart_mask), 32'd0);
    chk({name, "_busy"},      32'(busy),      32'd0);
    chk({name, "_overflow"},  32'(overflow),  32'd0);
  endtask

  initial begin
    int   bad;
    int   saved;
    logic req0;
    string nm;

    reset        = 1'b1;
    rom_loading  = 1'b0;
    rom_do       = 8'h00;
    rom_do_valid = 1'b0;

    //           n   gap dly size  hdr mask    writes ovf contig
    vecs[0]  = '{0,    4, 3, 0,    0, 'h0FF,  0,     0, 1};
    vecs[1]  = '{1,    4, 3, 1,    0, 'h0FF,  1,     0, 1};
    vecs[2]  = '{5,    4, 3, 5,    0, 'h0FF,  3,     0, 1};
    vecs[3]  = '{256,  4, 2, 256,  0, 'h0FF,  128,   0, 1};
    vecs[4]  = '{257,  4, 1, 257,  0, 'h1FF,  129,   0, 1};
    vecs[5]  = '{300,  3, 0, 300,  0, 'h1FF,  150,   0, 1};
    vecs[6]  = '{512,  4, 3, 512,  1, 'h0FF,  256,   0, 1};
    vecs[7]  = '{768,  4, 3, 768,  0, 'h3FF,  384,   0, 1};
    vecs[8]  = '{1536, 4, 3, 1536, 1, 'h3FF,  768,   0, 1};
    vecs[9]  = '{1025, 4, 3, 1025, 0, 'h7FF,  513,   0, 1};
    vecs[10] = '{4100, 4, 3, 4096, 0, 'hFFF,  2048,  1, 1};
    vecs[11] = '{40,   1, 20, 40,  0, 'h0FF,  -1,    1, 0};
    vecs[12] = '{6,    4, 3, 6,    0, 'h0FF,  3,     0, 1};

    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 13; v++) begin
      nm       = $sformatf("v%0d_n%0d", v, vecs[v].n);
      ack_dly  = vecs[v].dly;
      ack_hold = 1'b0;
      mon_start((vecs[v].n > CAP) ? CAP : vecs[v].n, vecs[v].contig[0]);
      @(negedge clk);
      rom_loading = 1'b1;
      feed(vecs[v].n, vecs[v].gap);
      chk({nm, "_sys_reset_held"}, 32'(sys_reset), 32'd1);
      rom_loading = 1'b0;
      wait_done(nm);
      chk({nm, "_cart_size"}, 32'(cart_size), 32'(vecs[v].size));
      chk({nm, "_cart_hdr"},  32'(cart_hdr),  32'(vecs[v].hdr));
      chk({nm, "_cart_mask"}, 32'(cart_mask), 32'(vecs[v].mask));
      chk({nm, "_overflow"},  32'(overflow),  32'(vecs[v].ovf));
      chk({nm, "_busy"},      32'(busy),      32'd0);
      if (vecs[v].writes >= 0) chk({nm, "_writes"}, 32'(wr_cnt), 32'(vecs[v].writes));
      else                     chk({nm, "_writes_some"}, 32'(wr_cnt > FD), 32'd1);
    end

    // Restart while draining with a request outstanding.
    ack_dly  = 3;
    ack_hold = 1'b1;
    mon_start(8, 1'b1);
    @(negedge clk);
    rom_loading = 1'b1;
    feed(8, 1);
    rom_loading = 1'b0;
    repeat (6) @(negedge clk);
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_one_issued", 32'(wr_cnt), 32'd1);
    chk("drain_outstanding", 32'(mem_req !== mem_ack), 32'd1);
    req0 = mem_req;
    mon_start(6, 1'b1);
    rom_loading = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req !== req0) bad++;
    end
    chk("restart_no_toggle", 32'(bad), 32'd0);
    ack_hold = 1'b0;
    feed(6, 4);
    rom_loading = 1'b0;
    wait_done("restart");
    chk("restart_cart_size", 32'(cart_size), 32'd6);
    chk("restart_writes", 32'(wr_cnt), 32'd3);
    chk("restart_cart_mask", 32'(cart_mask), 32'h0FF);

    // Reset in the middle of a download.
    ack_dly = 3;
    mon_start(20, 1'b1);
    @(negedge clk);
    rom_loading = 1'b1;
    feed(20, 4);
    reset        = 1'b1;
    rom_loading  = 1'b0;
    rom_do_valid = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    reset = 1'b0;
    saved = wr_cnt;
    bad   = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req !== 1'b0) bad++;
    end
    chk("midrst_no_toggle", 32'(bad), 32'd0);
    chk("midrst_no_writes", 32'(wr_cnt), 32'(saved));
    chk("midrst_sys_reset", 32'(sys_reset), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
